// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported, variable-latency backing memory
//                between the instruction-fetch port and the MEM-stage data
//                port.  One transaction at a time is sequenced with a
//                req/ack handshake toward the memory controller.  Data has
//                priority, a streak limit keeps fetch from starving and a
//                watchdog aborts transactions the memory never acknowledges.
//
//  Ports       :
//    clk, reset                       clock (rising edge), sync active-high reset
//    if_req/if_addr                   fetch request and address
//    if_rdata/if_ready                fetched word, one-cycle completion pulse
//    d_req/d_we/d_addr/d_wdata        data request, write enable, address, data
//    d_rdata/d_ready                  data read value, one-cycle completion pulse
//    err                              pulses with ready when the access timed out
//    stall_if/stall_d                 combinational pipeline stalls
//    mem_req/mem_we/mem_addr/mem_wdata registered memory request
//    mem_rdata/mem_ack                memory read data and one-cycle completion
//
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int          MAX_D_STREAK = 4,
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        err,
    output logic        stall_if,
    output logic        stall_d,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    // Streak counter only needs to reach MAX_D_STREAK; watchdog only needs
    // to reach TIMEOUT-1 because the transaction exits on that value.
    localparam int c_STREAK_W = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam int c_WDOG_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_D_STREAK);
    localparam logic [c_WDOG_W-1:0]   c_WDOG_LAST  = c_WDOG_W'(TIMEOUT - 1);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_BUSY_I = 2'd1;
    localparam logic [1:0] c_S_BUSY_D = 2'd2;

    logic [1:0]            r_state_q,     w_state_d;
    logic [c_STREAK_W-1:0] r_streak_q,    w_streak_d;
    logic [c_WDOG_W-1:0]   r_wdog_q,      w_wdog_d;
    logic                  r_mem_req_q,   w_mem_req_d;
    logic                  r_mem_we_q,    w_mem_we_d;
    logic [31:0]           r_mem_addr_q,  w_mem_addr_d;
    logic [31:0]           r_mem_wdata_q, w_mem_wdata_d;
    logic [31:0]           r_if_rdata_q,  w_if_rdata_d;
    logic [31:0]           r_d_rdata_q,   w_d_rdata_d;
    logic                  r_if_ready_q,  w_if_ready_d;
    logic                  r_d_ready_q,   w_d_ready_d;
    logic                  r_err_q,       w_err_d;

    logic w_grant_d;
    logic w_done;
    logic [31:0] w_done_data;

    // Data wins unless fetch is waiting and data already used its streak.
    assign w_grant_d   = d_req & ~(if_req & (r_streak_q == c_STREAK_MAX));
    // An ack in the watchdog's last cycle still counts as a normal completion.
    assign w_done      = mem_ack | (r_wdog_q == c_WDOG_LAST);
    assign w_done_data = mem_ack ? mem_rdata : ERR_DATA;

    always_comb begin
        w_state_d     = r_state_q;
        w_streak_d    = r_streak_q;
        w_wdog_d      = r_wdog_q;
        w_mem_req_d   = r_mem_req_q;
        w_mem_we_d    = r_mem_we_q;
        w_mem_addr_d  = r_mem_addr_q;
        w_mem_wdata_d = r_mem_wdata_q;
        w_if_rdata_d  = r_if_rdata_q;
        w_d_rdata_d   = r_d_rdata_q;
        w_if_ready_d  = 1'b0;
        w_d_ready_d   = 1'b0;
        w_err_d       = 1'b0;

        case (r_state_q)
            c_S_IDLE: begin
                w_wdog_d = '0;
                if (w_grant_d) begin
                    w_state_d     = c_S_BUSY_D;
                    w_mem_req_d   = 1'b1;
                    w_mem_we_d    = d_we;
                    w_mem_addr_d  = d_addr;
                    w_mem_wdata_d = d_wdata;
                    if (!if_req) begin
                        w_streak_d = '0;
                    end else if (r_streak_q != c_STREAK_MAX) begin
                        w_streak_d = r_streak_q + 1'b1;
                    end
                end else if (if_req) begin
                    w_state_d    = c_S_BUSY_I;
                    w_mem_req_d  = 1'b1;
                    w_mem_we_d   = 1'b0;
                    w_mem_addr_d = if_addr;
                    w_streak_d   = '0;
                end
            end

            c_S_BUSY_I, c_S_BUSY_D: begin
                if (w_done) begin
                    w_state_d   = c_S_IDLE;
                    w_mem_req_d = 1'b0;
                    w_wdog_d    = '0;
                    w_err_d     = ~mem_ack;
                    if (r_state_q == c_S_BUSY_D) begin
                        w_d_ready_d = 1'b1;
                        w_d_rdata_d = w_done_data;
                    end else begin
                        w_if_ready_d = 1'b1;
                        w_if_rdata_d = w_done_data;
                    end
                end else begin
                    w_wdog_d = r_wdog_q + 1'b1;
                end
            end

            default: begin
                w_state_d   = c_S_IDLE;
                w_mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= c_S_IDLE;
            r_streak_q    <= '0;
            r_wdog_q      <= '0;
            r_mem_req_q   <= 1'b0;
            r_mem_we_q    <= 1'b0;
            r_mem_addr_q  <= '0;
            r_mem_wdata_q <= '0;
            r_if_rdata_q  <= '0;
            r_d_rdata_q   <= '0;
            r_if_ready_q  <= 1'b0;
            r_d_ready_q   <= 1'b0;
            r_err_q       <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_streak_q    <= w_streak_d;
            r_wdog_q      <= w_wdog_d;
            r_mem_req_q   <= w_mem_req_d;
            r_mem_we_q    <= w_mem_we_d;
            r_mem_addr_q  <= w_mem_addr_d;
            r_mem_wdata_q <= w_mem_wdata_d;
            r_if_rdata_q  <= w_if_rdata_d;
            r_d_rdata_q   <= w_d_rdata_d;
            r_if_ready_q  <= w_if_ready_d;
            r_d_ready_q   <= w_d_ready_d;
            r_err_q       <= w_err_d;
        end
    end

    assign mem_req   = r_mem_req_q;
    assign mem_we    = r_mem_we_q;
    assign mem_addr  = r_mem_addr_q;
    assign mem_wdata = r_mem_wdata_q;
    assign if_rdata  = r_if_rdata_q;
    assign d_rdata   = r_d_rdata_q;
    assign if_ready  = r_if_ready_q;
    assign d_ready   = r_d_ready_q;
    assign err       = r_err_q;

    assign stall_if  = if_req & ~r_if_ready_q;
    assign stall_d   = d_req & ~r_d_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter.  Directed scenarios
//                followed by randomized fetch/data traffic, checked against a
//                transaction-level reference model of the arbitration rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int          c_MAXS = 4;
    localparam int          c_TO   = 255;
    localparam logic [31:0] c_ERRD = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, err, stall_if, stall_d, mem_req, mem_we;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state: consecutive data grants while fetch waited,
    // and the last value each port should be holding.
    int          m_streak = 0;
    logic [31:0] m_if_rdata = 32'h0;
    logic [31:0] m_d_rdata  = 32'h0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(
        .MAX_D_STREAK (c_MAXS),
        .TIMEOUT      (c_TO),
        .ERR_DATA     (c_ERRD)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .err       (err),
        .stall_if  (stall_if),
        .stall_d   (stall_d),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        if_req    = 1'b0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        mem_ack   = 1'b0;
        if_addr   = 32'h0;
        d_addr    = 32'h0;
        d_wdata   = 32'h0;
        mem_rdata = 32'h0;
        tick;
        tick;
        reset      = 1'b0;
        m_streak   = 0;
        m_if_rdata = 32'h0;
        m_d_rdata  = 32'h0;
    endtask

    task automatic new_if;
        if_req  = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic new_d;
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom & 32'hFFFF_FFFC;
        d_wdata = $urandom;
    endtask

    // One complete transaction starting from an idle arbiter whose next edge
    // arbitrates.  mode 0: ack after 1+waits busy cycles; mode 1: memory
    // never acks; mode 2: ack lands in the very last watchdog cycle.
    task automatic do_txn(input int mode, input int waits, input logic [31:0] rd,
                          output bit got_d, output int g_cyc, output int d_cyc);
        bit          exp_d;
        logic [31:0] e_addr, e_wd, e_rd;
        logic        e_we;
        int          n;
        exp_d = d_req && !(if_req && m_streak == c_MAXS);
        if (exp_d) begin
            e_addr = d_addr; e_we = d_we; e_wd = d_wdata;
        end else begin
            e_addr = if_addr; e_we = 1'b0; e_wd = 32'h0;
        end
        if (exp_d) m_streak = if_req ? ((m_streak < c_MAXS) ? m_streak + 1 : c_MAXS) : 0;
        else       m_streak = 0;

        tick;
        g_cyc = cyc;
        check("grant_mem_req", 32'(mem_req), 32'd1);
        check("grant_mem_addr", mem_addr, e_addr);
        check("grant_mem_we", 32'(mem_we), 32'(e_we));
        if (exp_d) check("grant_mem_wdata", mem_wdata, e_wd);
        check("ready_err_low_after_pulse", 32'({if_ready, d_ready, err}), 32'd0);

        n = (mode == 0) ? 1 + waits : c_TO - 1;
        repeat (n) tick;
        check("busy_mem_req_held", 32'(mem_req), 32'd1);
        check("busy_mem_addr_held", mem_addr, e_addr);
        check("busy_no_ready", 32'({if_ready, d_ready}), 32'd0);
        check("busy_stall", 32'({stall_if, stall_d}), 32'({if_req, d_req}));

        if (mode != 1) begin
            mem_ack   = 1'b1;
            mem_rdata = rd;
        end
        tick;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        d_cyc     = cyc;
        e_rd = (mode == 1) ? c_ERRD : rd;
        if (exp_d) m_d_rdata = e_rd;
        else       m_if_rdata = e_rd;
        check("done_ready", 32'({if_ready, d_ready}), exp_d ? 32'd1 : 32'd2);
        check("done_err", 32'(err), (mode == 1) ? 32'd1 : 32'd0);
        check("done_if_rdata", if_rdata, m_if_rdata);
        check("done_d_rdata", d_rdata, m_d_rdata);
        check("done_mem_req", 32'(mem_req), 32'd0);
        check("done_stall", 32'({stall_if, stall_d}), 32'({if_req & exp_d, d_req & ~exp_d}));
        got_d = exp_d;
    endtask

    initial begin
        bit       gd;
        int       gc, dc, gc2, dc2;
        logic [5:0] order, exp_order;

        // Reset state
        do_reset;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rdata", if_rdata | d_rdata, 32'd0);
        check("rst_pulses", 32'({if_ready, d_ready, err}), 32'd0);

        // Fetch with two wait cycles
        if_req = 1'b1; if_addr = 32'h40;
        do_txn(0, 2, 32'h8C080004, gd, gc, dc);
        check("fetch_data", if_rdata, 32'h8C080004);
        if_req = 1'b0;
        tick;

        // Simultaneous write and fetch: data first, fetch 3 cycles later
        do_reset;
        if_req = 1'b1; if_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h84; d_wdata = 32'h7;
        do_txn(0, 0, 32'h0, gd, gc, dc);
        check("simul_first_is_d", 32'(gd), 32'd1);
        d_req = 1'b0;
        do_txn(0, 0, 32'h11, gd, gc2, dc2);
        check("simul_second_is_i", 32'(gd), 32'd0);
        check("simul_ready_gap", 32'(dc2 - dc), 32'd3);
        if_req = 1'b0;
        tick;

        // Streak limit: both held for six transactions
        do_reset;
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wdata = 32'h0;
        order = 6'b0;
        for (int i = 0; i < 6; i++) begin
            do_txn(0, 0, $urandom, gd, gc, dc);
            order[i] = gd;
        end
        exp_order = 6'b101111;
        check("streak_grant_order", 32'(order), 32'(exp_order));
        if_req = 1'b0; d_req = 1'b0;
        tick;

        // Watchdog timeout on a data read, then a normal access
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        do_txn(1, 0, 32'h0, gd, gc, dc);
        check("timeout_cycles", 32'(dc - gc), 32'(c_TO));
        check("timeout_data", d_rdata, c_ERRD);
        d_addr = 32'h504;
        do_txn(0, 1, 32'hCAFE0001, gd, gc, dc);
        check("after_timeout_data", d_rdata, 32'hCAFE0001);
        // Ack collides with the last watchdog cycle: ack wins
        d_addr = 32'h508;
        do_txn(2, 0, 32'h13572468, gd, gc, dc);
        check("ack_at_limit_data", d_rdata, 32'h13572468);
        d_req = 1'b0;
        tick;

        // Reset during BUSY_D, stray ack afterwards
        do_reset;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        tick;
        check("rst_mid_granted", 32'(mem_req), 32'd1);
        tick;
        reset = 1'b1;
        tick;
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check("rst_mid_no_ready", 32'({d_ready, err}), 32'd0);
        reset = 1'b0; d_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1234;
        tick;
        mem_ack = 1'b0;
        check("stray_ack_no_ready", 32'({if_ready, d_ready, err}), 32'd0);
        check("stray_ack_rdata", d_rdata, 32'd0);
        check("stray_ack_mem_req", 32'(mem_req), 32'd0);
        m_streak = 0; m_if_rdata = 32'h0; m_d_rdata = 32'h0;

        // Bubble: zero-wait fetch with req held
        if_req = 1'b1; if_addr = 32'h40;
        do_txn(0, 0, 32'h2222, gd, gc, dc);
        check("zero_wait_latency", 32'(dc - gc), 32'd2);
        do_txn(0, 0, 32'h3333, gd, gc2, dc2);
        check("bubble_next_grant", 32'(gc2 - dc), 32'd1);
        if_req = 1'b0;
        tick;

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            if (!if_req && !d_req) begin
                if ($urandom_range(0, 1) == 1) new_if();
                else new_d();
            end
            do_txn(0, $urandom_range(0, 3), $urandom, gd, gc, dc);
            if (gd) begin
                if ($urandom_range(0, 3) != 0) new_d();
                else d_req = 1'b0;
                if (!if_req && $urandom_range(0, 2) == 0) new_if();
            end else begin
                if ($urandom_range(0, 1) == 1) new_if();
                else if_req = 1'b0;
                if (!d_req && $urandom_range(0, 1) == 1) new_d();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
